uart_alu_requester: RTL and testbench
=====================================

// Module: uart_alu_requester
// PURPOSE
//  Host-side initiator for the UART ALU command protocol. Accepts one ALU request
//  (opcode, operand A, operand B) on a start handshake and writes three bytes into
//  the UART TX FIFO: opcode, A, B. It then pops the single result byte from the
//  UART RX FIFO and returns it with a done pulse, or pulses timeout if no byte arrives.
//  Sits between a test/host controller and the uart TX/RX FIFOs.
// PARAMETERS
//  DATA_WIDTH      8      UART byte width; also the operand and result width
//  OPCODE_SZ       6      opcode width; must be <= DATA_WIDTH
//  TIMEOUT_CYCLES  50000  max cycles spent in WAIT_RESULT; counter width is $clog2(TIMEOUT_CYCLES+1)
// PORTS
//  i_clk        in   1           clock
//  i_reset      in   1           synchronous, active-high reset
//  i_start      in   1           request strobe; sampled only in IDLE
//  i_op_code    in   OPCODE_SZ   ALU opcode, latched on accepted start
//  i_op_a       in   DATA_WIDTH  operand A, latched on accepted start
//  i_op_b       in   DATA_WIDTH  operand B, latched on accepted start
//  o_ready      out  1           1 when in IDLE
//  i_tx_full    in   1           TX FIFO full
//  o_wr_uart    out  1           TX FIFO write strobe
//  o_w_data     out  DATA_WIDTH  TX FIFO write data
//  i_rx_empty   in   1           RX FIFO empty
//  i_r_data     in   DATA_WIDTH  RX FIFO head, first-word fall-through
//  o_rd_uart    out  1           RX FIFO pop strobe
//  o_result     out  DATA_WIDTH  last received result, registered
//  o_done       out  1           1-cycle pulse: o_result is valid
//  o_timeout    out  1           1-cycle pulse: no result within TIMEOUT_CYCLES
// BEHAVIOUR
//  Single clock; reset is synchronous and active-high.
//  Reset, including mid-operation:
//   - next edge: state = IDLE; o_result, o_done, o_timeout, timeout counter and latched request are 0.
//   - bytes already pushed to the TX FIFO are not recalled.
//  FIFO rules:
//   - a byte is written on any edge where o_wr_uart=1; o_wr_uart=1 only when i_tx_full=0.
//   - a byte is popped on any edge where o_rd_uart=1; o_rd_uart=1 only when i_rx_empty=0.
//   - o_wr_uart, o_w_data and o_rd_uart are combinational from state and the FIFO flags.
//   - o_w_data = 0 whenever o_wr_uart = 0.
//  States:
//   - IDLE
//       o_ready = 1.
//       If ~i_rx_empty: o_rd_uart = 1 and the stale byte is discarded; no done pulse.
//       If i_start: latch the request and go to SEND_OP. Drain and start may coincide.
//   - SEND_OP
//       If ~i_tx_full: o_wr_uart = 1, o_w_data = {zero-pad, opcode}, go to SEND_A.
//       Else hold the state.
//   - SEND_A   same rule with o_w_data = A; go to SEND_B.
//   - SEND_B   same rule with o_w_data = B; clear the counter and go to WAIT_RESULT.
//   - WAIT_RESULT
//       If ~i_rx_empty: o_rd_uart = 1, o_result <= i_r_data, o_done <= 1, go to IDLE.
//       Else, if counter == TIMEOUT_CYCLES-1: o_timeout <= 1, go to IDLE; o_result unchanged.
//       Else counter increments by 1.
//       If a byte and the timeout occur in the same cycle, the result wins.
//  Other rules:
//   - i_start outside IDLE is ignored; it is not queued.
//   - o_done and o_timeout are never high together.
//  Latency, FIFOs not stalled: start accepted at edge 0; writes at edges 1,2,3;
//   WAIT_RESULT from cycle 4; o_done high one cycle after the pop edge.
// TESTING
//  1 Basic: start op=6'h20, A=8'h05, B=8'h03, tx never full, 8'h08 in RX at cycle 6
//    -> writes 8'h20,8'h05,8'h03 at edges 1-3; pop at edge 6; o_done=1 at cycle 7; o_result=8'h08.
//  2 Backpressure: same request with i_tx_full=1 for cycles 1-4
//    -> no writes until cycle 5; bytes 8'h20,8'h05,8'h03 at edges 5,6,7, in order.
//  3 Timeout: TIMEOUT_CYCLES=16, RX stays empty
//    -> o_timeout=1 for exactly one cycle at cycle 20; o_done stays 0; o_ready=1 at cycle 20.
//  4 Stale drain: RX holds 8'hAA,8'hBB while IDLE
//    -> two pop pulses and no o_done; a following basic request still completes correctly.
//  5 Ignore/reset: i_start pulsed during SEND_A -> ignored;
//    reset asserted in SEND_A -> IDLE next edge, all outputs 0, no further writes.
//  6 Race: result byte arrives in the cycle the counter hits TIMEOUT_CYCLES-1
//    -> o_done=1, o_timeout stays 0.

Source files
------------

// File: rtl/uart_alu_requester_if.sv
// Bundles the host request handshake and the UART TX/RX FIFO signals of uart_alu_requester.
// master is the requester itself; slave is its environment (host controller plus FIFOs).
interface uart_alu_requester_if #(
    parameter int DATA_WIDTH = 8,
    parameter int OPCODE_SZ  = 6
);
    logic                  i_start;
    logic [OPCODE_SZ-1:0]  i_op_code;
    logic [DATA_WIDTH-1:0] i_op_a;
    logic [DATA_WIDTH-1:0] i_op_b;
    logic                  o_ready;
    logic                  i_tx_full;
    logic                  o_wr_uart;
    logic [DATA_WIDTH-1:0] o_w_data;
    logic                  i_rx_empty;
    logic [DATA_WIDTH-1:0] i_r_data;
    logic                  o_rd_uart;
    logic [DATA_WIDTH-1:0] o_result;
    logic                  o_done;
    logic                  o_timeout;

    modport master (
        input  i_start, i_op_code, i_op_a, i_op_b, i_tx_full, i_rx_empty, i_r_data,
        output o_ready, o_wr_uart, o_w_data, o_rd_uart, o_result, o_done, o_timeout
    );

    modport slave (
        output i_start, i_op_code, i_op_a, i_op_b, i_tx_full, i_rx_empty, i_r_data,
        input  o_ready, o_wr_uart, o_w_data, o_rd_uart, o_result, o_done, o_timeout
    );
endinterface

// File: rtl/uart_alu_requester.sv
// Host-side UART ALU initiator: sends opcode, A, B into the TX FIFO, then waits for one
// result byte from the RX FIFO, reporting it with o_done or giving up with o_timeout.
module uart_alu_requester #(
    parameter int DATA_WIDTH     = 8,
    parameter int OPCODE_SZ      = 6,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input logic                  i_clk,
    input logic                  i_reset,
    uart_alu_requester_if.master bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SEND_OP, SEND_A, SEND_B, WAIT_RESULT} state_t;

    state_t                state;
    state_t                state_next;
    logic [OPCODE_SZ-1:0]  op_code_q;
    logic [DATA_WIDTH-1:0] op_a_q;
    logic [DATA_WIDTH-1:0] op_b_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  done_q;
    logic                  timeout_q;
    logic [CW-1:0]         count_q;
    logic                  ready;
    logic                  wr_uart;
    logic                  rd_uart;
    logic [DATA_WIDTH-1:0] w_data;

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (bus.i_start)     state_next = SEND_OP;
            SEND_OP:     if (!bus.i_tx_full)  state_next = SEND_A;
            SEND_A:      if (!bus.i_tx_full)  state_next = SEND_B;
            SEND_B:      if (!bus.i_tx_full)  state_next = WAIT_RESULT;
            WAIT_RESULT: if (!bus.i_rx_empty || count_q == LAST_COUNT) state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    // FIFO strobes are combinational so a freed slot or a fresh byte is used the same cycle.
    always_comb begin
        ready   = 1'b0;
        wr_uart = 1'b0;
        rd_uart = 1'b0;
        w_data  = '0;
        case (state)
            IDLE: begin
                ready   = 1'b1;
                rd_uart = !bus.i_rx_empty;
            end
            SEND_OP: begin
                wr_uart = !bus.i_tx_full;
                if (!bus.i_tx_full) w_data = DATA_WIDTH'(op_code_q);
            end
            SEND_A: begin
                wr_uart = !bus.i_tx_full;
                if (!bus.i_tx_full) w_data = op_a_q;
            end
            SEND_B: begin
                wr_uart = !bus.i_tx_full;
                if (!bus.i_tx_full) w_data = op_b_q;
            end
            WAIT_RESULT: rd_uart = !bus.i_rx_empty;
            default: ready = 1'b0;
        endcase
    end

    // A byte arriving on the last wait cycle still counts as a result, not a timeout.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            op_code_q <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= '0;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        op_code_q <= bus.i_op_code;
                        op_a_q    <= bus.i_op_a;
                        op_b_q    <= bus.i_op_b;
                    end
                end
                SEND_B: if (!bus.i_tx_full) count_q <= '0;
                WAIT_RESULT: begin
                    if (!bus.i_rx_empty) begin
                        result_q <= bus.i_r_data;
                        done_q   <= 1'b1;
                    end else if (count_q == LAST_COUNT) begin
                        timeout_q <= 1'b1;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_ready   = ready;
    assign bus.o_wr_uart = wr_uart;
    assign bus.o_w_data  = w_data;
    assign bus.o_rd_uart = rd_uart;
    assign bus.o_result  = result_q;
    assign bus.o_done    = done_q;
    assign bus.o_timeout = timeout_q;
endmodule

// File: tb/tb_uart_alu_requester.sv
// Bench for uart_alu_requester: queue-based FIFO environment, transaction-level model
// compared every cycle, directed scenarios with literal expectations, then random traffic.
module tb_uart_alu_requester;
    localparam int DW = 8;
    localparam int OW = 6;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_alu_requester_if #(.DATA_WIDTH(DW), .OPCODE_SZ(OW)) bus();

    uart_alu_requester #(.DATA_WIDTH(DW), .OPCODE_SZ(OW), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    int assertions = 0;
    int failures   = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_log[$];
    int         pop_count  = 0;
    int         done_count = 0;

    // Request model: a request is a list of three bytes, sent in order, then a bounded wait.
    bit         m_on = 1'b0;
    bit         m_busy;
    int         m_sent;
    int         m_waited;
    logic [7:0] m_bytes[3];
    logic [7:0] m_result;
    bit         m_done;
    bit         m_timeout;

    bit         s_rd = 1'b0;
    bit         s_wr = 1'b0;
    logic [7:0] s_wdata = 8'h00;
    bit         exp_wr;
    bit         exp_rd;
    logic [7:0] exp_wd;

    function automatic void refresh_rx();
        bus.i_rx_empty = (rx_q.size() == 0);
        bus.i_r_data   = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit start, input logic [5:0] op, input logic [7:0] a,
                                 input logic [7:0] b, input bit tx_full);
        bus.i_start   = start;
        bus.i_op_code = op;
        bus.i_op_a    = a;
        bus.i_op_b    = b;
        bus.i_tx_full = tx_full;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic waitSample();
        @(negedge clk);
    endtask

    task automatic doReset();
        rx_q.delete();
        refresh_rx();
        applyStimulus(1'b0, 6'h00, 8'h00, 8'h00, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic checkLog(input string tag, input int base, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] exp_b[3];
        exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2;
        checkOutput({tag, "_nbytes"}, 32'(tx_log.size() - base), 32'd3);
        for (int i = 0; i < 3; i++)
            checkOutput({tag, "_byte"}, (base + i < tx_log.size()) ? 32'(tx_log[base + i]) : 32'hFFFF_FFFF,
                        32'(exp_b[i]));
    endtask

    // Basic request: start at cycle 0, result byte 8'h08 appears at cycle 6, done at cycle 7.
    task automatic runBasic(input string tag);
        int base;
        base = tx_log.size();
        applyStimulus(1'b1, 6'h20, 8'h05, 8'h03, 1'b0);
        tick();
        applyStimulus(1'b0, 6'h20, 8'h05, 8'h03, 1'b0);
        repeat (5) tick();
        rx_q.push_back(8'h08);
        refresh_rx();
        waitSample();
        checkOutput({tag, "_done_early"}, 32'(bus.o_done), 32'd0);
        tick();
        waitSample();
        checkOutput({tag, "_done"}, 32'(bus.o_done), 32'd1);
        checkOutput({tag, "_result"}, 32'(bus.o_result), 32'h08);
        checkLog(tag, base, 8'h20, 8'h05, 8'h03);
    endtask

    // Per-cycle comparison against the model; also captures FIFO strobes for the environment.
    always @(negedge clk) begin
        s_rd    = bus.o_rd_uart;
        s_wr    = bus.o_wr_uart;
        s_wdata = bus.o_w_data;
        if (m_on) begin
            exp_wr = m_busy && (m_sent < 3) && !bus.i_tx_full;
            exp_wd = 8'h00;
            if (exp_wr) exp_wd = m_bytes[m_sent];
            exp_rd = !bus.i_rx_empty && (!m_busy || m_sent == 3);
            checkOutput("ready",   32'(bus.o_ready),   32'(!m_busy));
            checkOutput("wr_uart", 32'(bus.o_wr_uart), 32'(exp_wr));
            checkOutput("w_data",  32'(bus.o_w_data),  32'(exp_wd));
            checkOutput("rd_uart", 32'(bus.o_rd_uart), 32'(exp_rd));
            checkOutput("result",  32'(bus.o_result),  32'(m_result));
            checkOutput("done",    32'(bus.o_done),    32'(m_done));
            checkOutput("timeout", 32'(bus.o_timeout), 32'(m_timeout));
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            m_on = 1'b1; m_busy = 1'b0; m_sent = 0; m_waited = 0;
            m_result = 8'h00; m_done = 1'b0; m_timeout = 1'b0;
            for (int i = 0; i < 3; i++) m_bytes[i] = 8'h00;
        end else if (m_on) begin
            m_done = 1'b0;
            m_timeout = 1'b0;
            if (!m_busy) begin
                if (bus.i_start) begin
                    m_busy = 1'b1;
                    m_sent = 0;
                    m_bytes[0] = 8'(bus.i_op_code);
                    m_bytes[1] = bus.i_op_a;
                    m_bytes[2] = bus.i_op_b;
                end
            end else if (m_sent < 3) begin
                if (!bus.i_tx_full) m_sent++;
                m_waited = 0;
            end else if (!bus.i_rx_empty) begin
                m_result = bus.i_r_data;
                m_done   = 1'b1;
                m_busy   = 1'b0;
            end else if (m_waited == TO - 1) begin
                m_timeout = 1'b1;
                m_busy    = 1'b0;
            end else begin
                m_waited++;
            end
        end
        #1;
        if (s_rd && rx_q.size() > 0) begin
            void'(rx_q.pop_front());
            pop_count++;
        end
        if (s_wr) tx_log.push_back(s_wdata);
        if (bus.o_done) done_count++;
        refresh_rx();
    end

    initial begin
        int base;
        int pc;
        int dc;
        reset = 1'b1;
        rx_q.delete();
        refresh_rx();
        applyStimulus(1'b0, 6'h00, 8'h00, 8'h00, 1'b0);
        repeat (2) tick();

        $display("[TB] basic request");
        doReset();
        waitSample();
        checkOutput("reset_ready",  32'(bus.o_ready),  32'd1);
        checkOutput("reset_result", 32'(bus.o_result), 32'd0);
        tick();
        runBasic("t1");

        $display("[TB] TX backpressure");
        doReset();
        base = tx_log.size();
        applyStimulus(1'b1, 6'h20, 8'h05, 8'h03, 1'b0);
        tick();
        applyStimulus(1'b0, 6'h20, 8'h05, 8'h03, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            waitSample();
            checkOutput("t2_stalled_wr", 32'(bus.o_wr_uart), 32'd0);
            tick();
        end
        applyStimulus(1'b0, 6'h20, 8'h05, 8'h03, 1'b0);
        repeat (3) tick();
        checkLog("t2", base, 8'h20, 8'h05, 8'h03);

        $display("[TB] timeout");
        doReset();
        applyStimulus(1'b1, 6'h01, 8'h02, 8'h03, 1'b0);
        tick();
        applyStimulus(1'b0, 6'h01, 8'h02, 8'h03, 1'b0);
        repeat (18) tick();
        waitSample();
        checkOutput("t3_timeout_c19", 32'(bus.o_timeout), 32'd0);
        tick();
        waitSample();
        checkOutput("t3_timeout_c20", 32'(bus.o_timeout), 32'd1);
        checkOutput("t3_ready_c20",   32'(bus.o_ready),   32'd1);
        checkOutput("t3_done_c20",    32'(bus.o_done),    32'd0);
        tick();
        waitSample();
        checkOutput("t3_timeout_c21", 32'(bus.o_timeout), 32'd0);

        $display("[TB] stale drain");
        doReset();
        pc = pop_count;
        dc = done_count;
        rx_q.push_back(8'hAA);
        rx_q.push_back(8'hBB);
        refresh_rx();
        repeat (3) tick();
        checkOutput("t4_pops",  32'(pop_count - pc),  32'd2);
        checkOutput("t4_dones", 32'(done_count - dc), 32'd0);
        runBasic("t4");

        $display("[TB] ignored start and mid-operation reset");
        doReset();
        base = tx_log.size();
        applyStimulus(1'b1, 6'h20, 8'h05, 8'h03, 1'b0);
        tick();
        applyStimulus(1'b0, 6'h20, 8'h05, 8'h03, 1'b0);
        tick();
        applyStimulus(1'b1, 6'h3F, 8'hFF, 8'hEE, 1'b0);
        tick();
        applyStimulus(1'b0, 6'h00, 8'h00, 8'h00, 1'b0);
        repeat (2) tick();
        rx_q.push_back(8'h08);
        refresh_rx();
        repeat (5) tick();
        checkLog("t5", base, 8'h20, 8'h05, 8'h03);
        checkOutput("t5_result", 32'(bus.o_result), 32'h08);
        checkOutput("t5_ready",  32'(bus.o_ready),  32'd1);
        doReset();
        base = tx_log.size();
        applyStimulus(1'b1, 6'h20, 8'h05, 8'h03, 1'b0);
        tick();
        applyStimulus(1'b0, 6'h20, 8'h05, 8'h03, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        waitSample();
        checkOutput("t5r_ready",   32'(bus.o_ready),   32'd1);
        checkOutput("t5r_wr",      32'(bus.o_wr_uart), 32'd0);
        checkOutput("t5r_done",    32'(bus.o_done),    32'd0);
        checkOutput("t5r_timeout", 32'(bus.o_timeout), 32'd0);
        checkOutput("t5r_result",  32'(bus.o_result),  32'd0);
        repeat (5) tick();
        checkOutput("t5r_nbytes", 32'(tx_log.size() - base), 32'd2);

        $display("[TB] result on final wait cycle");
        doReset();
        applyStimulus(1'b1, 6'h11, 8'h22, 8'h33, 1'b0);
        tick();
        applyStimulus(1'b0, 6'h11, 8'h22, 8'h33, 1'b0);
        repeat (18) tick();
        rx_q.push_back(8'h5A);
        refresh_rx();
        tick();
        waitSample();
        checkOutput("t6_done",    32'(bus.o_done),    32'd1);
        checkOutput("t6_timeout", 32'(bus.o_timeout), 32'd0);
        checkOutput("t6_result",  32'(bus.o_result),  32'h5A);
        tick();
        waitSample();
        checkOutput("t6_timeout_after", 32'(bus.o_timeout), 32'd0);

        $display("[TB] random traffic");
        doReset();
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 149) == 0);
            applyStimulus($urandom_range(0, 3) == 0, 6'($urandom), 8'($urandom), 8'($urandom),
                          $urandom_range(0, 3) == 0);
            if (rx_q.size() < 2 && $urandom_range(0, 11) == 0) begin
                rx_q.push_back(8'($urandom));
                refresh_rx();
            end
            tick();
        end
        reset = 1'b0;
        applyStimulus(1'b0, 6'h00, 8'h00, 8'h00, 1'b0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
